regfile_mp: RTL
===============

# regfile_mp

Parametrised general-purpose register file for the CPU datapath. It sits between decode, which drives the read addresses, and writeback, which drives the write port. It provides NUM_RD registered read ports with write-first bypass and a hardwired-zero R0. A programmable stack-pointer reset value and a sequential debug-dump engine let the bench or debug logic stream out every register, one per cycle.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (≥1)
- SP_IDX, 29, index of the stack-pointer register
- SP_RESET, 252, reset value loaded into R[SP_IDX]

Ports:
- elk  in  1  clock; all state changes on rising edge
- nrst  in  1  reset, asynchronous, active-low
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data, same packing as rd_addr
- wr_err  out  1  one-cycle pulse when a write to R0 is attempted
- dump_req  in  1  start a full register dump
- dump_busy  out  1  dump engine active
- dump_valid  out  1  dump_addr/dump_data hold a valid entry
- dump_addr  out  ADDR_W  index of the dumped register
- dump_data  out  DATA_W  value of the dumped register

## Operation
- Reset (nrst low, asynchronous): all registers cleared to 0, except R[SP_IDX], which is set to SP_RESET. All outputs are 0: rd_data, wr_err, dump_busy, dump_valid, dump_addr, dump_data. Dump FSM goes to IDLE.
- Write: on an edge with wr_en=1 and wr_addr≠0, R[wr_addr] ← wr_data.
- Write to R0: on an edge with wr_en=1 and wr_addr=0, no register changes and wr_err=1 for the following cycle. Otherwise wr_err=0.
- R0 always reads 0.
- Read: on each edge, each port p registers R[addr_p] into rd_data[p].
  - Bypass: if wr_en=1, wr_addr=addr_p and addr_p≠0 on that same edge, rd_data[p] takes wr_data (write-first).
  - Ports are independent; several ports may read the same address.
- Dump FSM states:
  - IDLE: dump_req=1 at an edge → SCAN, idx←0, dump_busy←1.
  - SCAN: each edge registers dump_valid←1, dump_addr←idx and dump_data←value of R[idx] with the same R0/bypass rules as the read ports, then idx←idx+1. On the edge that emits idx=DEPTH-1 → IDLE, dump_busy←0. On the next edge dump_valid←0.
  - dump_req is ignored while busy.
  - Writes continue normally during a dump; entries not yet emitted reflect the new values.
- Reset mid-dump: dump aborts immediately, all dump outputs go to 0, FSM goes to IDLE, and registers reset.

## Timing
- Read latency: 1 cycle from rd_addr sample to rd_data.
- Write visible to a same-cycle read via bypass; visible in storage from the next cycle.
- Dump, with dump_req sampled at edge T0:
  - dump_busy is high from after T0 through the edge that emits the last entry.
  - Entries 0..DEPTH-1 appear after edges T1..T_DEPTH, with dump_valid high for exactly DEPTH consecutive cycles.
  - dump_req=1 sampled on the edge that returns the FSM to IDLE is ignored.
  - The earliest restart is the following edge.
- wr_err: exactly one cycle per offending write edge.

## Structure
- Shared package regfile_pkg holds:
  - the dump FSM state enum (IDLE, SCAN)
  - default constants DATA_W_DEF, ADDR_W_DEF, SP_IDX_DEF, SP_RESET_DEF
- Sub-module regfile_dump_fsm (state, idx counter, handshake outputs) reads storage through one internal read tap. Storage, read ports and bypass stay in regfile_mp.
- Read-port logic uses a generate loop over NUM_RD.

## Test plan
- Reset: hold nrst low for 3 cycles, release.
  - Reading R29 → 252; reading R5 → 0.
  - All outputs are 0 during reset.
- Write then read: write R7=0xDEADBEEF, then read port 0 addr 7.
  - rd_data[0]=0xDEADBEEF one cycle after the read address is sampled.
  - Port 1 reading R0 → 0.
- Bypass: on the same edge, write R12=0x1234 and both ports read addr 12 → both ports show 0x1234 after that edge.
- R0 protection: write R0=0xFFFFFFFF.
  - wr_err pulses high for 1 cycle.
  - A subsequent read of R0 returns 0.
- Dump: preload R3=0xA5, pulse dump_req.
  - dump_valid is high for 32 consecutive cycles, with dump_addr 0..31 in order.
  - The entry with addr 3 carries 0xA5 and the entry with addr 29 carries 252.
  - A second dump_req while busy is ignored.
  - A write of R31=0x77 issued while dump_addr=10 appears in entry 31.
- Reset mid-dump: assert nrst low while dump_addr=15.
  - dump_busy and dump_valid drop to 0 immediately.
  - After release, a new dump starts cleanly at addr 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default constants for the multi-port register file
// and its debug-dump engine.
package regfile_pkg;

    localparam int          DATA_W_DEF   = 32;
    localparam int          ADDR_W_DEF   = 5;
    localparam int          SP_IDX_DEF   = 29;
    localparam int unsigned SP_RESET_DEF = 252;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } dump_state_e;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Sequential dump engine: walks every register index once, one per cycle,
// sampling storage through a single read tap owned by the register file.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              elk,
    input  logic              nrst,
    input  logic              dump_req,
    input  logic [DATA_W-1:0] tap_data,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data
);

    dump_state_e       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                valid_d = 1'b1;
                addr_d  = idx_q;
                data_d  = tap_data;
                idx_d   = idx_q + 1'b1;
                if (idx_q == '1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge elk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign tap_addr   = idx_q;
    assign dump_busy  = (state_q == SCAN);
    assign dump_valid = valid_q;
    assign dump_addr  = addr_q;
    assign dump_data  = data_q;

endmodule

// File: rtl/regfile_mp.sv
// General-purpose register file: NUM_RD registered read ports with write-first
// bypass, hardwired-zero R0, programmable SP reset value and a debug dump port.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int          DATA_W   = DATA_W_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int          NUM_RD   = 2,
    parameter int          SP_IDX   = SP_IDX_DEF,
    parameter int unsigned SP_RESET = SP_RESET_DEF
) (
    input  logic                     elk,
    input  logic                     nrst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic                     wr_err,
    input  logic                     dump_req,
    output logic                     dump_busy,
    output logic                     dump_valid,
    output logic [ADDR_W-1:0]        dump_addr,
    output logic [DATA_W-1:0]        dump_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0]        rd_data_d [NUM_RD];
    logic                     wr_err_q;
    logic [ADDR_W-1:0]        tap_addr;
    logic [DATA_W-1:0]        tap_data;

    // Value a reader sees this cycle: R0 is zero, a same-edge write wins over storage.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (addr == '0)                  return '0;
        else if (we && (waddr == addr))  return wdata;
        else                             return stored;
    endfunction

    // NOTE: the array is reset because SP must come up at SP_RESET and all others at zero.
    always_ff @(posedge elk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= (i == SP_IDX) ? DATA_W'(SP_RESET) : '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_p;
        assign addr_p       = rd_addr[p*ADDR_W +: ADDR_W];
        assign rd_data_d[p] = read_sel(addr_p, regs_q[addr_p], wr_en, wr_addr, wr_data);
    end

    always_ff @(posedge elk or negedge nrst) begin
        if (!nrst) begin
            rd_data_q <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data_q[p*DATA_W +: DATA_W] <= rd_data_d[p];
            end
            wr_err_q <= wr_en && (wr_addr == '0);
        end
    end

    assign tap_data = read_sel(tap_addr, regs_q[tap_addr], wr_en, wr_addr, wr_data);

    regfile_dump_fsm #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump (
        .elk        (elk),
        .nrst       (nrst),
        .dump_req   (dump_req),
        .tap_data   (tap_data),
        .tap_addr   (tap_addr),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data)
    );

    assign rd_data = rd_data_q;
    assign wr_err  = wr_err_q;

endmodule
